// File: rtl/hazard_unit.sv
// Hazard detection for the RV32 pipeline: EXEC operand forwarding,
// stall/flush steering and saturating stall/flush cycle counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_clr,
    input  logic             MEM_rd_reg_write,
    input  logic             WB_rd_reg_write,
    input  logic [4:0]       EXEC_rs1,
    input  logic [4:0]       EXEC_rs2,
    input  logic [4:0]       MEM_rd,
    input  logic [4:0]       WB_rd,
    input  logic             BRA,
    input  logic             JMP,
    input  logic             FETCH_valid,
    input  logic             MEM_valid,
    input  logic             EXEC_mem2reg,
    input  logic [4:0]       FETCH_rs1,
    input  logic [4:0]       FETCH_rs2,
    input  logic [4:0]       EXEC_rd,
    output logic [1:0]       FWD_rs1,
    output logic [1:0]       FWD_rs2,
    output logic             FETCH_stall,
    output logic             EXEC_stall,
    output logic             EXEC_flush,
    output logic             MEM_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic rs1_mem_hit;
    logic rs1_wb_hit;
    logic rs1_wb_only;
    logic rs2_mem_hit;
    logic rs2_wb_hit;
    logic rs2_wb_only;
    logic load_use;
    logic redirect;

    // x0 is hardwired zero, so it never matches a producer
    assign rs1_mem_hit = MEM_rd_reg_write
                       && (EXEC_rs1 != 5'd0)
                       && (EXEC_rs1 == MEM_rd);
    assign rs1_wb_hit  = WB_rd_reg_write
                       && (EXEC_rs1 != 5'd0)
                       && (EXEC_rs1 == WB_rd);
    assign rs2_mem_hit = MEM_rd_reg_write
                       && (EXEC_rs2 != 5'd0)
                       && (EXEC_rs2 == MEM_rd);
    assign rs2_wb_hit  = WB_rd_reg_write
                       && (EXEC_rs2 != 5'd0)
                       && (EXEC_rs2 == WB_rd);

    // MEM holds the newer value, so a WB hit only counts without a MEM hit
    assign rs1_wb_only = rs1_wb_hit && !rs1_mem_hit;
    assign rs2_wb_only = rs2_wb_hit && !rs2_mem_hit;

    assign load_use = EXEC_mem2reg
                    && (EXEC_rd != 5'd0)
                    && ((EXEC_rd == FETCH_rs1)
                     || (EXEC_rd == FETCH_rs2));

    assign redirect = BRA || JMP;

    // Select the rs1 operand source for EXEC
    always_comb begin
        FWD_rs1 = 2'b00;
        unique case (1'b1)
            rs1_mem_hit: FWD_rs1 = 2'b01;
            rs1_wb_only: FWD_rs1 = 2'b10;
            default:     FWD_rs1 = 2'b00;
        endcase
    end

    // Select the rs2 operand source for EXEC
    always_comb begin
        FWD_rs2 = 2'b00;
        unique case (1'b1)
            rs2_mem_hit: FWD_rs2 = 2'b01;
            rs2_wb_only: FWD_rs2 = 2'b10;
            default:     FWD_rs2 = 2'b00;
        endcase
    end

    // Stall/flush steering; a pending data access freezes everything
    always_comb begin
        FETCH_stall = 1'b1;
        EXEC_stall  = 1'b1;
        EXEC_flush  = 1'b0;
        MEM_flush   = 1'b0;
        if (MEM_valid) begin
            EXEC_stall  = 1'b0;
            // the wrong-path consumer is discarded on a redirect
            FETCH_stall = load_use && !redirect;
            EXEC_flush  = redirect || load_use || !FETCH_valid;
            MEM_flush   = redirect;
        end
    end

    // Saturating stall/flush cycle counters, clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (FETCH_stall && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (EXEC_flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, directed
// counter sequences and randomized stimulus against a reference model.
module tb_hazard_unit;

    typedef struct packed {
        logic       mwr;
        logic       wwr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] mrd;
        logic [4:0] wrd;
        logic       bra;
        logic       jmp;
        logic       fv;
        logic       mv;
        logic       m2r;
        logic [4:0] frs1;
        logic [4:0] frs2;
        logic [4:0] erd;
    } in_t;

    // e = {FWD_rs1, FWD_rs2, FETCH_stall, EXEC_stall, EXEC_flush, MEM_flush}
    typedef struct {
        in_t        i;
        logic [7:0] e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    in_t  cur;

    logic [1:0]  fwd1, fwd2, s_fwd1, s_fwd2;
    logic        fs, es, ef, mf, s_fs, s_es, s_ef, s_mf;
    logic [15:0] sc, fc;
    logic [3:0]  s_sc, s_fc;

    int checks = 0;
    int errors = 0;
    longint tot_stall = 0;
    longint tot_flush = 0;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
        .MEM_rd_reg_write(cur.mwr), .WB_rd_reg_write(cur.wwr),
        .EXEC_rs1(cur.rs1), .EXEC_rs2(cur.rs2),
        .MEM_rd(cur.mrd), .WB_rd(cur.wrd),
        .BRA(cur.bra), .JMP(cur.jmp),
        .FETCH_valid(cur.fv), .MEM_valid(cur.mv),
        .EXEC_mem2reg(cur.m2r),
        .FETCH_rs1(cur.frs1), .FETCH_rs2(cur.frs2),
        .EXEC_rd(cur.erd),
        .FWD_rs1(fwd1), .FWD_rs2(fwd2),
        .FETCH_stall(fs), .EXEC_stall(es),
        .EXEC_flush(ef), .MEM_flush(mf),
        .stall_cnt(sc), .flush_cnt(fc)
    );

    hazard_unit #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .cnt_clr(cnt_clr),
        .MEM_rd_reg_write(cur.mwr), .WB_rd_reg_write(cur.wwr),
        .EXEC_rs1(cur.rs1), .EXEC_rs2(cur.rs2),
        .MEM_rd(cur.mrd), .WB_rd(cur.wrd),
        .BRA(cur.bra), .JMP(cur.jmp),
        .FETCH_valid(cur.fv), .MEM_valid(cur.mv),
        .EXEC_mem2reg(cur.m2r),
        .FETCH_rs1(cur.frs1), .FETCH_rs2(cur.frs2),
        .EXEC_rd(cur.erd),
        .FWD_rs1(s_fwd1), .FWD_rs2(s_fwd2),
        .FETCH_stall(s_fs), .EXEC_stall(s_es),
        .EXEC_flush(s_ef), .MEM_flush(s_mf),
        .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    function automatic int src(logic [4:0] r, in_t x);
        if (r == 0) return 0;
        if (x.mwr && r == x.mrd) return 1;
        if (x.wwr && r == x.wrd) return 2;
        return 0;
    endfunction

    function automatic logic [7:0] model(in_t x);
        bit hazard, jump_away, stall, estall, eflush, mflush;
        hazard = x.m2r && x.erd != 0
               && (x.erd == x.frs1 || x.erd == x.frs2);
        jump_away = x.bra || x.jmp;
        if (!x.mv) begin
            stall = 1; estall = 1; eflush = 0; mflush = 0;
        end else begin
            estall = 0;
            stall  = hazard && !jump_away;
            eflush = jump_away || hazard || !x.fv;
            mflush = jump_away;
        end
        return {2'(src(x.rs1, x)), 2'(src(x.rs2, x)),
                stall, estall, eflush, mflush};
    endfunction

    function automatic longint sat(longint v, longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_comb(string name);
        check(name, {fwd1, fwd2, fs, es, ef, mf}, model(cur));
    endtask

    task automatic check_cnt(string name);
        check({name, "_sc"}, sc, sat(tot_stall, 65535));
        check({name, "_fc"}, fc, sat(tot_flush, 65535));
        check({name, "_ssc"}, s_sc, sat(tot_stall, 15));
        check({name, "_sfc"}, s_fc, sat(tot_flush, 15));
    endtask

    // One clock edge, advancing the model's running totals
    task automatic tick();
        logic [7:0] m;
        m = model(cur);
        @(posedge clk);
        if (!rst_n || cnt_clr) begin
            tot_stall = 0;
            tot_flush = 0;
        end else begin
            tot_stall += m[3];
            tot_flush += m[1];
        end
        #1;
    endtask

    vec_t vecs[15];
    in_t  lu;

    initial begin
        cur = '0;
        lu = '{mv: 1, fv: 1, m2r: 1, erd: 3, frs2: 3, default: 0};
        vecs[0]  = '{'0, 8'b00_00_1100};
        vecs[1]  = '{'{mwr: 1, wwr: 1, rs1: 5, mrd: 5, wrd: 5, rs2: 7,
                       mv: 1, fv: 1, default: 0}, 8'b01_00_0000};
        vecs[2]  = '{'{mwr: 1, wwr: 1, rs1: 5, mrd: 9, wrd: 5, rs2: 7,
                       mv: 1, fv: 1, default: 0}, 8'b10_00_0000};
        vecs[3]  = '{'{mwr: 1, wwr: 1, mv: 1, fv: 1, default: 0},
                     8'b00_00_0000};
        vecs[4]  = '{'{rs1: 4, mrd: 4, rs2: 6, wrd: 6, mv: 1, fv: 1,
                       default: 0}, 8'b00_00_0000};
        vecs[5]  = '{'{rs2: 6, wrd: 6, wwr: 1, mv: 1, fv: 1,
                       default: 0}, 8'b00_10_0000};
        vecs[6]  = '{lu, 8'b00_00_1010};
        vecs[7]  = '{'{mv: 1, fv: 1, m2r: 1, erd: 0, frs2: 0,
                       default: 0}, 8'b00_00_0000};
        vecs[8]  = '{'{mv: 1, fv: 1, m2r: 1, erd: 3, frs2: 3, bra: 1,
                       default: 0}, 8'b00_00_0011};
        vecs[9]  = '{'{mv: 1, fv: 1, m2r: 1, erd: 3, frs2: 3, jmp: 1,
                       default: 0}, 8'b00_00_0011};
        vecs[10] = '{'{mv: 1, fv: 1, m2r: 1, erd: 3, frs2: 3, jmp: 1,
                       bra: 1, default: 0}, 8'b00_00_0011};
        vecs[11] = '{'{mv: 0, bra: 1, fv: 0, default: 0}, 8'b00_00_1100};
        vecs[12] = '{'{mv: 1, fv: 0, default: 0}, 8'b00_00_0010};
        vecs[13] = '{'{mv: 1, fv: 1, m2r: 1, erd: 3, frs1: 3,
                       default: 0}, 8'b00_00_1010};
        vecs[14] = '{'{rs1: 5, mrd: 5, mwr: 1, mv: 0, default: 0},
                     8'b01_00_1100};

        // table applied while still in reset
        #2;
        check("reset_sc", sc, 0);
        check("reset_fc", fc, 0);
        foreach (vecs[k]) begin
            cur = vecs[k].i;
            #1;
            check($sformatf("vec%0d", k),
                  {fwd1, fwd2, fs, es, ef, mf}, vecs[k].e);
        end
        check("reset_hold_sc", sc, 0);

        // 3 memory-wait cycles then 2 fetch bubbles
        @(negedge clk);
        rst_n = 1'b1;
        cur = '0;
        repeat (3) tick();
        cur = '{mv: 1, fv: 0, default: 0};
        repeat (2) tick();
        check("seq_stall3", sc, 3);
        check("seq_flush2", fc, 2);
        check_cnt("seq");

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_sc", sc, 0);
        check("clr_fc", fc, 0);

        // async reset in mid-cycle
        cur = '0;
        repeat (4) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tot_stall = 0;
        tot_flush = 0;
        check("arst_sc", sc, 0);
        check("arst_fc", fc, 0);
        #2 rst_n = 1'b1;

        // saturation on the narrow instance
        cur = '0;
        repeat (20) tick();
        check("sat_small", s_sc, 15);
        check("sat_big", sc, 20);
        check_cnt("sat");

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            cur.mwr  = 1'($urandom);
            cur.wwr  = 1'($urandom);
            cur.rs1  = 5'($urandom_range(0, 3));
            cur.rs2  = 5'($urandom_range(0, 3));
            cur.mrd  = 5'($urandom_range(0, 3));
            cur.wrd  = 5'($urandom_range(0, 3));
            cur.bra  = ($urandom_range(0, 3) == 0);
            cur.jmp  = ($urandom_range(0, 3) == 0);
            cur.fv   = ($urandom_range(0, 4) != 0);
            cur.mv   = ($urandom_range(0, 4) != 0);
            cur.m2r  = 1'($urandom);
            cur.frs1 = 5'($urandom_range(0, 3));
            cur.frs2 = 5'($urandom_range(0, 3));
            cur.erd  = 5'($urandom_range(0, 3));
            cnt_clr  = ($urandom_range(0, 40) == 0);
            #1;
            check($sformatf("rnd%0d", n), {fwd1, fwd2, fs, es, ef, mf},
                  model(cur));
            tick();
            check_cnt($sformatf("rnd%0d", n));
        end
        cnt_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Hazard detection and resolution unit for the 5-stage RV32 pipeline (FETCH/EXEC/MEM/WB).
- Combinationally produces operand-forwarding selects for the EXEC stage, plus stall and flush controls for the pipeline registers.
- Holds two saturating performance counters: stall cycles and flush cycles.

Parameters:
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset; clears the counters.
- cnt_clr  in  1  synchronous clear of both counters.
- MEM_rd_reg_write  in  1  instruction in MEM writes rd.
- WB_rd_reg_write  in  1  instruction in WB writes rd.
- EXEC_rs1  in  5  EXEC-stage source register 1.
- EXEC_rs2  in  5  EXEC-stage source register 2.
- MEM_rd  in  5  MEM-stage destination register.
- WB_rd  in  5  WB-stage destination register.
- BRA  in  1  taken branch resolved in EXEC.
- JMP  in  1  jump (JAL/JALR) resolved in EXEC.
- FETCH_valid  in  1  instruction memory returned a valid word.
- MEM_valid  in  1  data memory access complete / ready.
- EXEC_mem2reg  in  1  EXEC-stage instruction is a load.
- FETCH_rs1  in  5  rs1 of the instruction being decoded/fetched.
- FETCH_rs2  in  5  rs2 of the instruction being decoded/fetched.
- EXEC_rd  in  5  EXEC-stage destination register.
- FWD_rs1  out  2  forward select for rs1: 00 none (register file), 01 from MEM, 10 from WB; 11 never driven.
- FWD_rs2  out  2  forward select for rs2, same encoding.
- FETCH_stall  out  1  hold PC and the FETCH/EXEC register.
- EXEC_stall  out  1  hold the EXEC/MEM register.
- EXEC_flush  out  1  insert a bubble into the EXEC stage register.
- MEM_flush  out  1  insert a bubble into the MEM stage register.
- stall_cnt  out  CNT_W  cycles with FETCH_stall=1.
- flush_cnt  out  CNT_W  cycles with EXEC_flush=1.

Behaviour:
- All FWD, stall and flush outputs are purely combinational; zero latency; independent of clk and rst_n.
- Forwarding, per source X in {rs1, rs2}:
  - If EXEC_X != 0, EXEC_X == MEM_rd and MEM_rd_reg_write, then FWD_X = 01.
  - Else if EXEC_X != 0, EXEC_X == WB_rd and WB_rd_reg_write, then FWD_X = 10.
  - Else FWD_X = 00.
  - MEM has priority over WB (it is the newer value).
  - x0 is never forwarded.
- Definitions:
  - load_use = EXEC_mem2reg & (EXEC_rd != 0) & (EXEC_rd == FETCH_rs1 | EXEC_rd == FETCH_rs2).
  - redirect = BRA | JMP.
- MEM_valid = 0 dominates all other conditions: FETCH_stall = 1, EXEC_stall = 1, EXEC_flush = 0, MEM_flush = 0.
- When MEM_valid = 1:
  - EXEC_stall = 0.
  - FETCH_stall = load_use & ~redirect. A redirect discards the wrong-path instruction, so no stall is needed.
  - EXEC_flush = redirect | load_use | ~FETCH_valid.
  - MEM_flush = redirect.
- BRA and JMP asserted together behave the same as either one alone.
- Counters:
  - rst_n low clears both counters to 0 asynchronously.
  - On posedge clk, cnt_clr = 1 clears both counters; cnt_clr has priority over increment.
  - Otherwise stall_cnt increments when FETCH_stall = 1, and flush_cnt increments when EXEC_flush = 1.
  - Both counters saturate at all-ones and never wrap.
- Reset values: stall_cnt = 0, flush_cnt = 0. Combinational outputs follow their inputs even while in reset.
- All-zero inputs give:
  - FWD = 00/00.
  - FETCH_stall = 1 and EXEC_stall = 1 (MEM_valid = 0).
  - Both flushes = 0.

Test Plan:
- Forwarding priority: MEM_rd_reg_write=1, WB_rd_reg_write=1, EXEC_rs1=5, MEM_rd=5, WB_rd=5, EXEC_rs2=7 -> FWD_rs1=01, FWD_rs2=00. Then set MEM_rd=9 -> FWD_rs1=10.
- x0 guard: EXEC_rs1=0, EXEC_rs2=0, MEM_rd=0, WB_rd=0, both reg_write=1 -> FWD_rs1=00, FWD_rs2=00. Also reg_write=0 with matching registers -> 00.
- Load-use: MEM_valid=1, FETCH_valid=1, EXEC_mem2reg=1, EXEC_rd=3, FETCH_rs2=3 -> FETCH_stall=1, EXEC_stall=0, EXEC_flush=1, MEM_flush=0. With EXEC_rd=0 instead -> all 0.
- Redirect: MEM_valid=1, BRA=1 (and separately JMP=1), with a load-use condition also present -> FETCH_stall=0, EXEC_stall=0, EXEC_flush=1, MEM_flush=1.
- Memory wait: MEM_valid=0, BRA=1, FETCH_valid=0 -> FETCH_stall=1, EXEC_stall=1, EXEC_flush=0, MEM_flush=0.
- Counters: reset, then 3 cycles MEM_valid=0, then 2 cycles FETCH_valid=0, MEM_valid=1 -> stall_cnt=3, flush_cnt=2. Assert cnt_clr -> both 0. Drop rst_n mid-cycle -> both 0 immediately. Force saturation (CNT_W=4, 20 stall cycles) -> stall_cnt=15.
